// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder
// Description : Registered instruction register plus combinational decode for
//               an 8-bit core. A small FSM sequences reset fill, the one-cycle
//               flush after a taken jump, and halt.
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               pm_data, alu_zero   - fetched word, ALU zero result
//               sync_reset, jmp, jmp_nz, jmp_addr, dont_jump
//                                   - program sequencer control
//               reg_en, src_sel, src_reg, imm, alu_func, alu_en
//                                   - datapath control
//               halted              - core halted
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder #(
  parameter logic       Z_RESET   = 1'b0,
  parameter logic [7:0] HALT_CODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       sync_reset,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jump,
  output logic [3:0] reg_en,
  output logic [1:0] src_sel,
  output logic [1:0] src_reg,
  output logic [3:0] imm,
  output logic [2:0] alu_func,
  output logic       alu_en,
  output logic       halted
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_LDI = 2'b00;
  localparam logic [1:0] c_OP_MOV = 2'b01;
  localparam logic [1:0] c_OP_ALU = 2'b10;
  localparam logic [1:0] c_OP_BR  = 2'b11;

  localparam logic [1:0] c_SRC_IMM = 2'd0;
  localparam logic [1:0] c_SRC_REG = 2'd1;
  localparam logic [1:0] c_SRC_ALU = 2'd2;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_ir;
  logic       r_z_flag;
  logic       w_ir_valid;
  logic       w_is_halt;
  logic       w_taken;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // --------------------------------------------------------------------------
  // State, instruction register and zero flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RST;
      r_ir     <= 8'h00;
      r_z_flag <= Z_RESET;
    end else begin
      r_state <= w_next_state;
      // The halt word stays in ir so the core remains parked.
      if (r_state != ST_HALT) begin
        r_ir <= pm_data;
      end
      // alu_en is only ever high in RUN, so the flag moves only on real ALU ops.
      if (alu_en) begin
        r_z_flag <= alu_zero;
      end
    end
  end

  assign w_ir_valid = (r_state == ST_RUN);
  assign w_is_halt  = (r_ir == HALT_CODE);
  assign w_taken    = jmp | (jmp_nz & ~r_z_flag);

  assign sync_reset = (r_state == ST_RST);
  assign halted     = (r_state == ST_HALT);
  assign dont_jump  = r_z_flag;

  // --------------------------------------------------------------------------
  // Instruction decode; everything stays zero unless ir holds a live word
  // --------------------------------------------------------------------------
  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    jmp_addr = 4'h0;
    reg_en   = 4'h0;
    src_sel  = c_SRC_IMM;
    src_reg  = 2'd0;
    imm      = 4'h0;
    alu_func = 3'd0;
    alu_en   = 1'b0;
    if (w_ir_valid && !w_is_halt) begin
      case (r_ir[7:6])
        c_OP_LDI: begin
          reg_en  = onehot(r_ir[5:4]);
          src_sel = c_SRC_IMM;
          imm     = r_ir[3:0];
        end
        c_OP_MOV: begin
          // A move onto itself has no effect, so no write is enabled.
          reg_en  = (r_ir[5:4] == r_ir[3:2]) ? 4'h0 : onehot(r_ir[5:4]);
          src_sel = c_SRC_REG;
          src_reg = r_ir[3:2];
        end
        c_OP_ALU: begin
          alu_en   = 1'b1;
          alu_func = r_ir[5:3];
          reg_en   = onehot({1'b0, r_ir[2]});
          src_sel  = c_SRC_ALU;
        end
        c_OP_BR: begin
          jmp_addr = r_ir[3:0];
          jmp      = (r_ir[5:4] == 2'b00);
          jmp_nz   = (r_ir[5:4] == 2'b01);
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST:   w_next_state = ST_FILL;
      ST_FILL:  w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_is_halt) begin
          w_next_state = ST_HALT;
        end else if (w_taken) begin
          // The word fetched behind the jump is loaded but never decoded.
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: w_next_state = ST_RUN;
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_RST;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decoder
// Description : Directed, table-driven bench for instruction_decoder. Each
//               table row is one clock cycle: the word and alu_zero presented
//               during that cycle and the decode expected during it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jump;
  logic [3:0] reg_en;
  logic [1:0] src_sel;
  logic [1:0] src_reg;
  logic [3:0] imm;
  logic [2:0] alu_func;
  logic       alu_en;
  logic       halted;

  instruction_decoder #(
    .Z_RESET   (1'b0),
    .HALT_CODE (8'hFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_data    (pm_data),
    .alu_zero   (alu_zero),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jump  (dont_jump),
    .reg_en     (reg_en),
    .src_sel    (src_sel),
    .src_reg    (src_reg),
    .imm        (imm),
    .alu_func   (alu_func),
    .alu_en     (alu_en),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sync_reset, jmp, jmp_nz, jmp_addr, dont_jump, reg_en, src_sel, src_reg,
  //  imm, alu_func, alu_en, halted}
  logic [24:0] act;
  assign act = {sync_reset, jmp, jmp_nz, jmp_addr, dont_jump, reg_en, src_sel,
                src_reg, imm, alu_func, alu_en, halted};

  typedef struct {
    logic [7:0]  pm;
    logic        az;
    logic [24:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_cmp;
  int n_bad;

  function automatic logic [24:0] mk(
    input logic sr, input logic j, input logic jnz, input logic [3:0] ja,
    input logic dj, input logic [3:0] re, input logic [1:0] ss,
    input logic [1:0] sreg, input logic [3:0] im, input logic [2:0] fn,
    input logic ae, input logic h);
    return {sr, j, jnz, ja, dj, re, ss, sreg, im, fn, ae, h};
  endfunction

  task automatic check(input string name, input logic [24:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h (sr=%b jmp=%b jnz=%b ja=%h dj=%b re=%b ss=%0d sreg=%0d imm=%h fn=%0d ae=%b h=%b) expected %h",
               name, act, sync_reset, jmp, jmp_nz, jmp_addr, dont_jump, reg_en,
               src_sel, src_reg, imm, alu_func, alu_en, halted, exp);
    end
  endtask

  // Called at a falling edge: present inputs, check this cycle's decode, and
  // move on to the next falling edge.
  task automatic step(input string name, input logic [7:0] pm, input logic az,
                      input logic [24:0] exp);
    pm_data  = pm;
    alu_zero = az;
    #1;
    check(name, exp);
    @(negedge clk);
  endtask

  logic [24:0] zero_out;
  logic [24:0] rst_out;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    zero_out = '0;
    rst_out  = mk(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 2'd0, 4'h0, 3'd0, 0, 0);

    //             pm     az   expected decode during this cycle
    vecs[0]  = '{8'h00, 1'b0, rst_out};                                          // RST
    vecs[1]  = '{8'h25, 1'b0, zero_out};                                         // FILL, mem[0]
    vecs[2]  = '{8'hC3, 1'b0, mk(0,0,0,4'h0,0,4'b0100,2'd0,2'd0,4'h5,3'd0,0,0)}; // LDI r2,5
    vecs[3]  = '{8'h12, 1'b0, mk(0,1,0,4'h3,0,4'b0000,2'd0,2'd0,4'h0,3'd0,0,0)}; // JMP 3
    vecs[4]  = '{8'h5C, 1'b0, zero_out};                                         // flush, mem[30]
    vecs[5]  = '{8'h54, 1'b0, mk(0,0,0,4'h0,0,4'b0010,2'd1,2'd3,4'h0,3'd0,0,0)}; // MOV r1,r3
    vecs[6]  = '{8'h9C, 1'b0, mk(0,0,0,4'h0,0,4'b0000,2'd1,2'd1,4'h0,3'd0,0,0)}; // MOV r1,r1 nop
    vecs[7]  = '{8'hD5, 1'b1, mk(0,0,0,4'h0,0,4'b0010,2'd2,2'd0,4'h0,3'd3,1,0)}; // ALU f3 -> r1, zero
    vecs[8]  = '{8'h8A, 1'b0, mk(0,0,1,4'h5,1,4'b0000,2'd0,2'd0,4'h0,3'd0,0,0)}; // JNZ 5 not taken
    vecs[9]  = '{8'hD5, 1'b0, mk(0,0,0,4'h0,1,4'b0001,2'd2,2'd0,4'h0,3'd1,1,0)}; // ALU f1 -> r0, nonzero
    vecs[10] = '{8'h33, 1'b0, mk(0,0,1,4'h5,0,4'b0000,2'd0,2'd0,4'h0,3'd0,0,0)}; // JNZ 5 taken
    vecs[11] = '{8'h0F, 1'b0, zero_out};                                         // flush, mem[50]
    vecs[12] = '{8'hFF, 1'b0, mk(0,0,0,4'h0,0,4'b0001,2'd0,2'd0,4'hF,3'd0,0,0)}; // LDI r0,F
    vecs[13] = '{8'h25, 1'b0, zero_out};                                         // halt word
    vecs[14] = '{8'hC3, 1'b0, mk(0,0,0,4'h0,0,4'h0,2'd0,2'd0,4'h0,3'd0,0,1)};    // HALT

    reset_n  = 1'b0;
    pm_data  = 8'h00;
    alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", rst_out);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), vecs[i].pm, vecs[i].az, vecs[i].exp);
    end

    // Halted core ignores whatever the memory presents.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("halt_hold%0d", i), 8'($urandom), 1'($urandom),
           mk(0,0,0,4'h0,0,4'h0,2'd0,2'd0,4'h0,3'd0,0,1));
    end

    // Asynchronous reset while halted, then a clean restart.
    #2 reset_n = 1'b0;
    #1 check("reset_in_halt", rst_out);
    @(negedge clk);
    reset_n = 1'b1;
    step("rst2_rst",  8'h00, 1'b0, rst_out);
    step("rst2_fill", 8'h9C, 1'b0, zero_out);
    step("rst2_alu",  8'hC3, 1'b1, mk(0,0,0,4'h0,0,4'b0010,2'd2,2'd0,4'h0,3'd3,1,0));
    step("rst2_jmp",  8'h25, 1'b0, mk(0,1,0,4'h3,1,4'h0,2'd0,2'd0,4'h0,3'd0,0,0));

    // Asynchronous reset in the flush cycle; zero flag must fall back too.
    pm_data = 8'h00;
    #1 check("flush_before_reset", mk(0,0,0,4'h0,1,4'h0,2'd0,2'd0,4'h0,3'd0,0,0));
    #1 reset_n = 1'b0;
    #1 check("reset_in_flush", rst_out);
    @(negedge clk);
    reset_n = 1'b1;
    step("rst3_rst",  8'h00, 1'b0, rst_out);
    step("rst3_fill", 8'h25, 1'b0, zero_out);
    step("rst3_ldi",  8'h00, 1'b0, mk(0,0,0,4'h0,0,4'b0100,2'd0,2'd0,4'h5,3'd0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
